load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request at a time, issues it to the data
// memory bus (reissuing while the bus rejects it), waits for the tagged load
// response, and reports completion with a one-cycle done pulse.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-high reset
//   req_*                  - request handshake and fields (store flag, funct3,
//                            address, right-aligned store data, destination id)
//   proc2Dmem_*            - bus command, size, address and lane-shifted data
//   Dmem2proc_response     - nonzero tag when the bus accepts the request
//   Dmem2proc_data/_tag    - returning load word and its tag
//   done, result,
//   done_dest, misaligned  - completion report, valid only while done is high
module load_store_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DEST_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_store_data,
    input  logic [DEST_W-1:0] req_dest,
    output logic [1:0]        proc2Dmem_command,
    output logic [1:0]        proc2Dmem_size,
    output logic [XLEN-1:0]   proc2Dmem_addr,
    output logic [XLEN-1:0]   proc2Dmem_data,
    input  logic [TAG_W-1:0]  Dmem2proc_response,
    input  logic [XLEN-1:0]   Dmem2proc_data,
    input  logic [TAG_W-1:0]  Dmem2proc_tag,
    output logic              done,
    output logic [XLEN-1:0]   result,
    output logic [DEST_W-1:0] done_dest,
    output logic              misaligned
);

    localparam int unsigned LaneW = $clog2(XLEN / 8);

    localparam logic [1:0] BusNone  = 2'd0;
    localparam logic [1:0] BusLoad  = 2'd1;
    localparam logic [1:0] BusStore = 2'd2;

    localparam logic [1:0] MemByte   = 2'd0;
    localparam logic [1:0] MemHalf   = 2'd1;
    localparam logic [1:0] MemWord   = 2'd2;
    localparam logic [1:0] MemDouble = 2'd3;

    localparam logic [XLEN-1:0] MaskByte = {XLEN{1'b1}} >> (XLEN - 8);
    localparam logic [XLEN-1:0] MaskHalf = {XLEN{1'b1}} >> (XLEN - 16);
    localparam logic [XLEN-1:0] MaskWord = {XLEN{1'b1}} >> (XLEN - 32);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic                is_store_q;
    logic [2:0]          funct3_q;
    logic [XLEN-1:0]     addr_q;
    logic [XLEN-1:0]     store_data_q;
    logic [DEST_W-1:0]   dest_q;
    logic [TAG_W-1:0]    tag_q;
    logic [XLEN-1:0]     result_q;
    logic                misaligned_q;

    logic                accept;
    logic                req_misaligned;
    logic                bus_granted;
    logic                tag_match;
    logic [LaneW-1:0]    lane;
    logic [XLEN-1:0]     size_mask;
    logic [XLEN-1:0]     load_shifted;
    logic                load_sign;
    logic [XLEN-1:0]     load_ext;

    assign accept      = req_valid && (state_q == StIdle);
    assign bus_granted = (state_q == StIssue) && (Dmem2proc_response != '0);
    // Only WAIT compares tags, so a tag arriving alongside the grant is ignored.
    assign tag_match   = (state_q == StWait) && (Dmem2proc_tag == tag_q);

    always_comb begin
        req_misaligned = 1'b0;
        unique case (req_funct3[1:0])
            MemByte:   req_misaligned = 1'b0;
            MemHalf:   req_misaligned = req_addr[0];
            MemWord:   req_misaligned = |req_addr[1:0];
            MemDouble: req_misaligned = |req_addr[2:0];
            default:   req_misaligned = 1'b0;
        endcase
    end

    // Size mask and lane shared by store alignment and load extraction.
    always_comb begin
        lane      = addr_q[LaneW-1:0];
        size_mask = '1;
        unique case (funct3_q[1:0])
            MemByte:   size_mask = MaskByte;
            MemHalf:   size_mask = MaskHalf;
            MemWord:   size_mask = MaskWord;
            MemDouble: size_mask = '1;
            default:   size_mask = '1;
        endcase
    end

    always_comb begin
        load_shifted = Dmem2proc_data >> {lane, 3'b000};
        load_sign    = 1'b0;
        unique case (funct3_q[1:0])
            MemByte:   load_sign = load_shifted[7];
            MemHalf:   load_sign = load_shifted[15];
            MemWord:   load_sign = load_shifted[31];
            MemDouble: load_sign = load_shifted[XLEN-1];
            default:   load_sign = 1'b0;
        endcase
        // Bits above the access size come from the sign unless unsigned.
        load_ext = (load_shifted & size_mask) |
                   ((load_sign && !funct3_q[2]) ? ~size_mask : '0);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = req_misaligned ? StResp : StIssue;
            end
            StIssue: begin
                if (bus_granted) state_d = is_store_q ? StResp : StWait;
            end
            StWait: begin
                if (tag_match) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            is_store_q   <= 1'b0;
            funct3_q     <= '0;
            addr_q       <= '0;
            store_data_q <= '0;
            dest_q       <= '0;
            tag_q        <= '0;
            result_q     <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q   <= req_is_store;
                funct3_q     <= req_funct3;
                addr_q       <= req_addr;
                store_data_q <= req_store_data;
                dest_q       <= req_dest;
                misaligned_q <= req_misaligned;
                result_q     <= '0;
            end
            if (bus_granted && !is_store_q) tag_q <= Dmem2proc_response;
            if (tag_match) result_q <= load_ext;
        end
    end

    always_comb begin
        req_ready         = (state_q == StIdle);
        proc2Dmem_command = BusNone;
        if (state_q == StIssue) proc2Dmem_command = is_store_q ? BusStore : BusLoad;
        proc2Dmem_size    = funct3_q[1:0];
        proc2Dmem_addr    = addr_q;
        proc2Dmem_data    = (store_data_q & size_mask) << {lane, 3'b000};
        done              = (state_q == StResp);
        result            = done ? result_q : '0;
        done_dest         = done ? dest_q : '0;
        misaligned        = done && misaligned_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, a reset-abandon
// sequence, and randomized transactions checked against an arithmetic model.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_store_data = '0;
    logic [4:0]  req_dest = '0;
    logic [1:0]  proc2Dmem_command;
    logic [1:0]  proc2Dmem_size;
    logic [31:0] proc2Dmem_addr;
    logic [31:0] proc2Dmem_data;
    logic [3:0]  Dmem2proc_response = '0;
    logic [31:0] Dmem2proc_data = '0;
    logic [3:0]  Dmem2proc_tag = '0;
    logic        done;
    logic [31:0] result;
    logic [4:0]  done_dest;
    logic        misaligned;

    int n_cmp = 0;
    int n_fail = 0;

    load_store_unit #(.XLEN(32), .TAG_W(4), .DEST_W(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_is_store       (req_is_store),
        .req_funct3         (req_funct3),
        .req_addr           (req_addr),
        .req_store_data     (req_store_data),
        .req_dest           (req_dest),
        .proc2Dmem_command  (proc2Dmem_command),
        .proc2Dmem_size     (proc2Dmem_size),
        .proc2Dmem_addr     (proc2Dmem_addr),
        .proc2Dmem_data     (proc2Dmem_data),
        .Dmem2proc_response (Dmem2proc_response),
        .Dmem2proc_data     (Dmem2proc_data),
        .Dmem2proc_tag      (Dmem2proc_tag),
        .done               (done),
        .result             (result),
        .done_dest          (done_dest),
        .misaligned         (misaligned)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input string what, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on byte offsets and access widths.
    function automatic int unsigned acc_bits(input logic [2:0] f3);
        return 8 << f3[1:0];
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned bytes = 1 << f3[1:0];
        return (addr % bytes) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        longint unsigned v  = longint'(word) >> (8 * (addr % 4));
        int unsigned     nb = acc_bits(f3);
        if (nb < 32) begin
            longint unsigned m = longint'(1) << nb;
            v = v % m;
            if (!f3[2] && v >= m / 2) v = v + (longint'(1) << 32) - m;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] data);
        longint unsigned v  = longint'(data);
        int unsigned     nb = acc_bits(f3);
        if (nb < 32) v = v % (longint'(1) << nb);
        v = v << (8 * (addr % 4));
        return 32'(v);
    endfunction

    // Runs one request through the reactive bus model and checks everything seen.
    task automatic do_txn(input string nm, input bit st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] word, input int rej, input logic [3:0] rtag,
                          input int dly, input logic [3:0] wtag, input bit early,
                          input logic [31:0] exp_res, input bit exp_mis,
                          input logic [31:0] exp_bus);
        int          issues = 0;
        int          dones = 0;
        int          done_at = -1;
        int          rej_left = rej;
        int          tag_at = -1;
        int          exp_done_at;
        logic [31:0] got_res = '0;
        logic [4:0]  got_dest = '0;
        logic        got_mis = 1'b0;
        logic [4:0]  dest = 5'($urandom);
        exp_done_at = exp_mis ? 0 : (st ? rej + 1 : rej + 2 + dly);
        @(negedge clock);
        chk(nm, "ready", req_ready, 1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_store_data = sdata; req_dest = dest;
        @(negedge clock);
        req_valid = 1'b0;
        req_store_data = $urandom;
        for (int c = 0; c < 60; c++) begin
            Dmem2proc_response = '0;
            Dmem2proc_tag = '0;
            Dmem2proc_data = $urandom;
            if (proc2Dmem_command != 2'd0) begin
                issues++;
                chk(nm, "cmd", proc2Dmem_command, st ? 2'd2 : 2'd1);
                chk(nm, "bus_addr", proc2Dmem_addr, addr);
                chk(nm, "bus_size", proc2Dmem_size, f3[1:0]);
                if (st) chk(nm, "bus_data", proc2Dmem_data, exp_bus);
                if (rej_left > 0) rej_left--;
                else begin
                    Dmem2proc_response = rtag;
                    if (!st) begin
                        tag_at = c + 1 + dly;
                        if (early) Dmem2proc_tag = rtag;
                    end
                end
            end else if (tag_at >= 0 && c < tag_at) begin
                Dmem2proc_tag = wtag;
            end
            if (c == tag_at) begin
                Dmem2proc_tag = rtag;
                Dmem2proc_data = word;
            end
            if (done) begin
                dones++;
                done_at = c; got_res = result; got_dest = done_dest; got_mis = misaligned;
            end
            if (done_at >= 0 && c >= done_at + 2) break;
            @(negedge clock);
        end
        Dmem2proc_response = '0;
        Dmem2proc_tag = '0;
        chk(nm, "issues", issues, exp_mis ? 0 : rej + 1);
        chk(nm, "dones", dones, 1);
        chk(nm, "done_at", done_at, exp_done_at);
        chk(nm, "result", got_res, exp_res);
        chk(nm, "done_dest", got_dest, dest);
        chk(nm, "misaligned", got_mis, exp_mis);
        chk(nm, "ready_after", req_ready, 1);
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] word;
        int          rej;
        logic [3:0]  rtag;
        int          dly;
        logic [3:0]  wtag;
        bit          early;
        logic [31:0] exp_res;
        bit          exp_mis;
        logic [31:0] exp_bus;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //          st f3    addr     sdata         word        rej tag dly wtg early res mis bus
        tbl[0]  = '{0, 3'b000, 32'h1003, 32'h0, 32'h80FFFFFF, 0, 4'd3, 3, 4'd0, 0,
                    32'hFFFFFF80, 0, 32'h0};
        tbl[1]  = '{0, 3'b101, 32'h2002, 32'h0, 32'hBEEF1234, 0, 4'd1, 0, 4'd0, 0,
                    32'h0000BEEF, 0, 32'h0};
        tbl[2]  = '{1, 3'b000, 32'h11, 32'hAB, 32'h0, 2, 4'd5, 0, 4'd0, 0,
                    32'h0, 0, 32'h0000AB00};
        tbl[3]  = '{0, 3'b010, 32'h6, 32'h0, 32'h12345678, 0, 4'd1, 0, 4'd0, 0,
                    32'h0, 1, 32'h0};
        tbl[4]  = '{0, 3'b010, 32'h8, 32'h0, 32'h12345678, 0, 4'd2, 2, 4'd7, 0,
                    32'h12345678, 0, 32'h0};
        tbl[5]  = '{0, 3'b010, 32'h4, 32'h0, 32'hCAFEF00D, 1, 4'd4, 1, 4'd0, 1,
                    32'hCAFEF00D, 0, 32'h0};
        tbl[6]  = '{0, 3'b001, 32'h1002, 32'h0, 32'h80010000, 0, 4'd9, 0, 4'd0, 0,
                    32'hFFFF8001, 0, 32'h0};
        tbl[7]  = '{0, 3'b100, 32'h3, 32'h0, 32'h80FFFFFF, 0, 4'd15, 1, 4'd3, 0,
                    32'h00000080, 0, 32'h0};
        tbl[8]  = '{1, 3'b001, 32'h2, 32'h1234ABCD, 32'h0, 0, 4'd6, 0, 4'd0, 0,
                    32'h0, 0, 32'hABCD0000};
        tbl[9]  = '{1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1, 4'd2, 0, 4'd0, 0,
                    32'h0, 0, 32'hDEADBEEF};
        tbl[10] = '{1, 3'b001, 32'h1, 32'h1234, 32'h0, 0, 4'd1, 0, 4'd0, 0,
                    32'h0, 1, 32'h0};
        tbl[11] = '{0, 3'b011, 32'h4, 32'h0, 32'h0, 0, 4'd1, 0, 4'd0, 0,
                    32'h0, 1, 32'h0};
        tbl[12] = '{0, 3'b011, 32'h8, 32'h0, 32'h89ABCDEF, 0, 4'd8, 0, 4'd0, 0,
                    32'h89ABCDEF, 0, 32'h0};
        tbl[13] = '{1, 3'b000, 32'h3, 32'hFFFFFF5A, 32'h0, 0, 4'd11, 0, 4'd0, 0,
                    32'h0, 0, 32'h5A000000};

        // Reset state.
        repeat (2) @(negedge clock);
        chk("reset", "ready", req_ready, 1);
        chk("reset", "done", done, 0);
        chk("reset", "result", result, 0);
        chk("reset", "done_dest", done_dest, 0);
        chk("reset", "misaligned", misaligned, 0);
        chk("reset", "cmd", proc2Dmem_command, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_txn($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].addr, tbl[i].sdata,
                   tbl[i].word, tbl[i].rej, tbl[i].rtag, tbl[i].dly, tbl[i].wtag,
                   tbl[i].early, tbl[i].exp_res, tbl[i].exp_mis, tbl[i].exp_bus);
        end

        // Reset while waiting for a load tag abandons the load.
        begin
            int dones = 0;
            @(negedge clock);
            req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
            req_addr = 32'h10; req_dest = 5'd9;
            @(negedge clock);
            req_valid = 1'b0;
            chk("rst_wait", "cmd", proc2Dmem_command, 1);
            Dmem2proc_response = 4'd6;
            @(negedge clock);
            Dmem2proc_response = '0;
            chk("rst_wait", "in_wait", req_ready, 0);
            reset = 1'b1;
            #2;
            reset = 1'b0;
            chk("rst_wait", "ready", req_ready, 1);
            for (int c = 0; c < 5; c++) begin
                Dmem2proc_tag = 4'd6;
                Dmem2proc_data = 32'hA5A5A5A5;
                @(negedge clock);
                if (done) dones++;
            end
            Dmem2proc_tag = '0;
            chk("rst_wait", "dones", dones, 0);
            chk("rst_wait", "ready_after", req_ready, 1);
        end

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            bit          st = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] addr = $urandom;
            logic [31:0] sdata = $urandom;
            logic [31:0] word = $urandom;
            logic [3:0]  rtag = 4'($urandom_range(15, 1));
            logic [3:0]  wtag = 4'($urandom);
            bit          mis;
            if ($urandom_range(2, 0) != 0) addr = addr & ~32'((1 << f3[1:0]) - 1);
            if (wtag == rtag) wtag = 4'd0;
            mis = model_mis(f3, addr);
            do_txn($sformatf("rnd%0d", i), st, f3, addr, sdata, word,
                   int'($urandom_range(3, 0)), rtag, int'($urandom_range(4, 0)), wtag,
                   1'($urandom),
                   (st || mis) ? 32'h0 : model_load(f3, addr, word), mis,
                   model_store(f3, addr, sdata));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
